// File: rtl/vending_machine_change.sv
// Newspaper vending controller: collects nickel/dime/quarter credit against PRICE,
// dispenses one item per sale, refunds change as one-cycle nickel pulses, tracks stock.
module vending_machine_change #(
    parameter int PRICE    = 3,
    parameter int STOCK    = 8,
    parameter int STOCK_W  = 4,
    parameter int CREDIT_W = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                restock,
    output logic                newspaper,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic                busy,
    output logic                sold_out,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock_count
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    localparam logic [CREDIT_W:0]   PRICE_X   = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   CREDIT_MX = (CREDIT_W+1)'((2**CREDIT_W) - 1);
    localparam logic [STOCK_W-1:0]  STOCK_L   = STOCK_W'(STOCK);

    state_t                state;
    logic                  coin_ok;
    logic [CREDIT_W:0]     coin_units;
    logic [CREDIT_W:0]     sum;
    logic [CREDIT_W:0]     after_sale;

    function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] c);
        logic [CREDIT_W:0] v;
        case (c)
            2'd1:    v = (CREDIT_W+1)'(1);
            2'd2:    v = (CREDIT_W+1)'(2);
            2'd3:    v = (CREDIT_W+1)'(5);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Narrow the extended-width credit arithmetic back to the register width.
    function automatic logic [CREDIT_W-1:0] sat_credit(input logic [CREDIT_W:0] v);
        logic [CREDIT_W-1:0] r;
        if (v > CREDIT_MX)
            r = CREDIT_W'(CREDIT_MX);
        else
            r = CREDIT_W'(v);
        return r;
    endfunction

    always_comb begin
        coin_ok    = (coin != 2'd0) && (state == COLLECT) && !sold_out;
        coin_units = coin_ok ? coin_value(coin) : '0;
        sum        = {1'b0, credit} + coin_units;
        after_sale = (sum >= PRICE_X) ? (sum - PRICE_X) : '0;
    end

    assign newspaper     = (state == VEND);
    assign change_nickel = (state == CHANGE);
    assign busy          = (state != COLLECT);
    assign sold_out      = (stock_count == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= COLLECT;
            credit      <= '0;
            stock_count <= STOCK_L;
            coin_reject <= 1'b0;
        end else begin
            // Any coin that is not credited is bounced back by the acceptor.
            coin_reject <= (coin != 2'd0) && !coin_ok;

            case (state)
                COLLECT: begin
                    if (cancel) begin
                        credit <= sat_credit(sum);
                        if (sum != '0)
                            state <= CHANGE;
                    end else if (coin_ok) begin
                        if (sum >= PRICE_X) begin
                            credit <= sat_credit(after_sale);
                            state  <= VEND;
                        end else begin
                            credit <= sat_credit(sum);
                        end
                    end
                    if (restock)
                        stock_count <= STOCK_L;
                end

                VEND: begin
                    if (stock_count != '0)
                        stock_count <= stock_count - STOCK_W'(1);
                    state <= (credit != '0) ? CHANGE : COLLECT;
                end

                CHANGE: begin
                    if (credit != '0)
                        credit <= credit - CREDIT_W'(1);
                    if (credit <= CREDIT_W'(1))
                        state <= COLLECT;
                end

                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_machine_change.sv
// Directed plus random bench for vending_machine_change; a per-cycle reference model
// pushes expected outputs to a scoreboard queue that is popped after each clock edge.
module tb_vending_machine_change;

    localparam int PRICE    = 3;
    localparam int STOCK    = 8;
    localparam int STOCK_W  = 4;
    localparam int CREDIT_W = 6;

    logic                clock;
    logic                reset;
    logic [1:0]          coin;
    logic                cancel;
    logic                restock;
    logic                newspaper;
    logic                change_nickel;
    logic                coin_reject;
    logic                busy;
    logic                sold_out;
    logic [CREDIT_W-1:0] credit;
    logic [STOCK_W-1:0]  stock_count;

    vending_machine_change #(
        .PRICE(PRICE), .STOCK(STOCK), .STOCK_W(STOCK_W), .CREDIT_W(CREDIT_W)
    ) dut (
        .clock(clock), .reset(reset), .coin(coin), .cancel(cancel), .restock(restock),
        .newspaper(newspaper), .change_nickel(change_nickel), .coin_reject(coin_reject),
        .busy(busy), .sold_out(sold_out), .credit(credit), .stock_count(stock_count)
    );

    typedef struct {
        int np;
        int cn;
        int rej;
        int bsy;
        int so;
        int cr;
        int st;
    } exp_t;

    exp_t sb[$];

    int vectors    = 0;
    int miscompares = 0;
    int np_cnt = 0, cn_cnt = 0, rj_cnt = 0;

    // Reference model state: 0 collect, 1 vend, 2 change.
    int m_state = 0, m_credit = 0, m_stock = STOCK, m_rej = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int c, input bit cn, input bit rs, input bit rstn);
        int val;
        if (!rstn) begin
            m_state = 0; m_credit = 0; m_stock = STOCK; m_rej = 0;
            return;
        end
        m_rej = (c != 0) && (m_state != 0 || m_stock == 0);
        case (m_state)
            0: begin
                val = 0;
                if (c != 0 && m_stock != 0)
                    val = (c == 1) ? 1 : (c == 2) ? 2 : 5;
                if (cn) begin
                    m_credit += val;
                    if (m_credit > 0) m_state = 2;
                end else if (val > 0) begin
                    if (m_credit + val >= PRICE) begin
                        m_credit = m_credit + val - PRICE;
                        m_state  = 1;
                    end else begin
                        m_credit += val;
                    end
                end
                if (rs) m_stock = STOCK;
            end
            1: begin
                m_stock--;
                m_state = (m_credit > 0) ? 2 : 0;
            end
            default: begin
                m_credit--;
                if (m_credit == 0) m_state = 0;
            end
        endcase
    endtask

    task automatic step(input int c, input bit cn = 0, input bit rs = 0, input bit rstn = 1);
        exp_t e, g;
        coin = c[1:0]; cancel = cn; restock = rs; reset = rstn;
        model(c, cn, rs, rstn);
        e.np = (m_state == 1); e.cn = (m_state == 2); e.bsy = (m_state != 0);
        e.rej = m_rej; e.so = (m_stock == 0); e.cr = m_credit; e.st = m_stock;
        sb.push_back(e);
        @(posedge clock);
        #1;
        g = sb.pop_front();
        check("newspaper",     32'(newspaper),     32'(g.np));
        check("change_nickel", 32'(change_nickel), 32'(g.cn));
        check("coin_reject",   32'(coin_reject),   32'(g.rej));
        check("busy",          32'(busy),          32'(g.bsy));
        check("sold_out",      32'(sold_out),      32'(g.so));
        check("credit",        32'(credit),        32'(g.cr));
        check("stock_count",   32'(stock_count),   32'(g.st));
        np_cnt += int'(newspaper);
        cn_cnt += int'(change_nickel);
        rj_cnt += int'(coin_reject);
        coin = 2'd0; cancel = 1'b0; restock = 1'b0; reset = 1'b1;
    endtask

    task automatic clr_counts();
        np_cnt = 0; cn_cnt = 0; rj_cnt = 0;
    endtask

    initial begin
        reset = 1'b0; coin = 2'd0; cancel = 1'b0; restock = 1'b0;

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("reset_credit", 32'(credit), 0);
        check("reset_stock",  32'(stock_count), STOCK);
        check("reset_busy",   32'(busy), 0);

        // Three nickels: exact price, no change.
        clr_counts();
        step(1); step(1); step(1);
        check("3n_vend_now", 32'(newspaper), 1);
        step(0); step(0);
        check("3n_np_pulses", np_cnt, 1);
        check("3n_cn_pulses", cn_cnt, 0);
        check("3n_stock", 32'(stock_count), 7);

        // Dime + dime: one nickel back.
        clr_counts();
        step(2); step(2);
        check("dd_credit_vend", 32'(credit), 1);
        step(0); step(0); step(0);
        check("dd_np_pulses", np_cnt, 1);
        check("dd_cn_pulses", cn_cnt, 1);
        check("dd_idle", 32'(busy), 0);

        // Quarter, then a quarter during VEND that must bounce.
        clr_counts();
        step(3);
        step(3);
        check("q_rej_now", 32'(coin_reject), 1);
        check("q_credit_kept", 32'(credit), 2);
        step(0); step(0); step(0);
        check("q_cn_pulses", cn_cnt, 2);
        check("q_rj_pulses", rj_cnt, 1);

        // Nickel then cancel with a dime: full refund, no sale.
        clr_counts();
        step(1);
        step(2, 1);
        check("c_credit", 32'(credit), 3);
        step(0); step(0); step(0); step(0);
        check("c_np_pulses", np_cnt, 0);
        check("c_cn_pulses", cn_cnt, 3);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            int c;
            c = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            step(c, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        end

        // Sell out completely, then restock.
        step(0, 0, 0, 0);
        for (int k = 0; k < STOCK; k++) begin
            step(2); step(1); step(0);
        end
        check("so_flag", 32'(sold_out), 1);
        step(1);
        check("so_rej", 32'(coin_reject), 1);
        check("so_credit", 32'(credit), 0);
        step(0, 1);
        check("so_cancel_idle", 32'(busy), 0);
        step(1, 0, 1);
        check("so_restock_rej", 32'(coin_reject), 1);
        check("so_restock_flag", 32'(sold_out), 0);
        check("so_restock_cnt", 32'(stock_count), STOCK);
        step(2); step(1);
        check("so_vend_again", 32'(newspaper), 1);
        step(0);

        // Reset during the first, then the second, change pulse of a quarter sale.
        step(3); step(0);
        check("r1_pulse", 32'(change_nickel), 1);
        step(0, 0, 0, 0);
        check("r1_cn", 32'(change_nickel), 0);
        check("r1_credit", 32'(credit), 0);
        check("r1_stock", 32'(stock_count), STOCK);
        step(3); step(0); step(0);
        check("r2_pulse", 32'(change_nickel), 1);
        step(0, 0, 0, 0);
        check("r2_cn", 32'(change_nickel), 0);
        check("r2_credit", 32'(credit), 0);
        check("r2_stock", 32'(stock_count), STOCK);
        check("r2_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
